// File: rtl/discharge_telemetry_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : discharge_telemetry_tx_pkg
// Brief   : Shared constants, frame word indices and TX state encoding.
//           Frame length depends on TELEMETRY_CHECKSUM_EN.
// Revision: 1.0  initial release
// ============================================================================
package discharge_telemetry_tx_pkg;

  localparam logic [7:0]  HEADER_TAG_DEF = 8'hA5;
  localparam logic [15:0] WIDTH_SAT_DEF  = 16'hFFFF;

  localparam logic [2:0] W_HDR   = 3'd0;
  localparam logic [2:0] W_WIDTH = 3'd1;
  localparam logic [2:0] W_PEAK  = 3'd2;
  localparam logic [2:0] W_VMIN  = 3'd3;
  localparam logic [2:0] W_CSUM  = 3'd4;

`ifdef TELEMETRY_CHECKSUM_EN
  localparam logic [2:0] FRAME_LEN = 3'd5;
`else
  localparam logic [2:0] FRAME_LEN = 3'd4;
`endif
  localparam logic [2:0] LAST_IDX = FRAME_LEN - 3'd1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/discharge_telemetry_tx_pulse_meter.sv
`default_nettype none
// ============================================================================
// Module  : discharge_telemetry_tx_pulse_meter
// Brief   : Edge detect on is_operation; accumulates width, peak current and
//           minimum voltage of the current pulse. Emits a fall strobe.
// Revision: 1.0  initial release
// ============================================================================
module discharge_telemetry_tx_pulse_meter
  import discharge_telemetry_tx_pkg::*;
#(
  parameter logic [15:0] WIDTH_SAT = WIDTH_SAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               is_operation,
  input  logic signed [15:0] sample_current,
  input  logic signed [15:0] sample_voltage,
  output logic               fall,
  output logic [15:0]        width,
  output logic signed [15:0] peak,
  output logic signed [15:0] vmin
);

  logic               r_op_d;
  logic [15:0]        r_width;
  logic signed [15:0] r_peak;
  logic signed [15:0] r_vmin;
  logic               w_rise;

  assign w_rise = is_operation & ~r_op_d;
  assign fall   = ~is_operation & r_op_d;
  assign width  = r_width;
  assign peak   = r_peak;
  assign vmin   = r_vmin;

  // Results hold after the fall so the framer can capture them on the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_d  <= 1'b0;
      r_width <= 16'd0;
      r_peak  <= 16'sd0;
      r_vmin  <= 16'sd0;
    end else begin
      r_op_d <= is_operation;
      if (w_rise) begin
        r_width <= 16'd1;
        r_peak  <= sample_current;
        r_vmin  <= sample_voltage;
      end else if (is_operation) begin
        if (r_width < WIDTH_SAT) r_width <= r_width + 16'd1;
        if (sample_current > r_peak) r_peak <= sample_current;
        if (sample_voltage < r_vmin) r_vmin <= sample_voltage;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/discharge_telemetry_tx.sv
`default_nettype none
// ============================================================================
// Module  : discharge_telemetry_tx
// Brief   : Packs per-pulse discharge measurements into 16-bit word frames
//           for the SPI slave TX path. Define TELEMETRY_CHECKSUM_EN to append
//           an XOR checksum word.
// Revision: 1.0  initial release
// ============================================================================
module discharge_telemetry_tx
  import discharge_telemetry_tx_pkg::*;
#(
  parameter logic [7:0]  HEADER_TAG = HEADER_TAG_DEF,
  parameter logic [15:0] WIDTH_SAT  = WIDTH_SAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_operation,
  input  logic [15:0] sample_current,
  input  logic [15:0] sample_voltage,
  input  logic        report_enable,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_active,
  output logic [15:0] drop_count
);

  tx_state_t   r_state;
  tx_state_t   w_state_next;
  logic [2:0]  r_idx;
  logic [7:0]  r_seq;
  logic [15:0] r_sh_width;
  logic [15:0] r_sh_peak;
  logic [15:0] r_sh_vmin;
  logic [15:0] r_drop;
  logic [15:0] w_word;
  logic        w_fall;
  logic [15:0] w_width;
  logic [15:0] w_peak;
  logic [15:0] w_vmin;
  logic        w_accept;
  logic        w_last;
  logic        w_capture;
  logic        w_drop;

  discharge_telemetry_tx_pulse_meter #(
    .WIDTH_SAT (WIDTH_SAT)
  ) u_meter (
    .clk            (clk),
    .rst_n          (rst_n),
    .is_operation   (is_operation),
    .sample_current (sample_current),
    .sample_voltage (sample_voltage),
    .fall           (w_fall),
    .width          (w_width),
    .peak           (w_peak),
    .vmin           (w_vmin)
  );

  assign w_accept  = (r_state == ST_SEND) & tx_ready;
  assign w_last    = (r_idx == LAST_IDX);
  assign w_capture = (r_state == ST_IDLE) & w_fall & report_enable;
  assign w_drop    = (r_state == ST_SEND) & w_fall & report_enable;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_capture) w_state_next = ST_SEND;
      ST_SEND: if (w_accept && w_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Shadow registers decouple the frame being sent from the next measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= W_HDR;
      r_seq      <= 8'd0;
      r_sh_width <= 16'd0;
      r_sh_peak  <= 16'd0;
      r_sh_vmin  <= 16'd0;
      r_drop     <= 16'd0;
    end else begin
      if (w_capture) begin
        r_sh_width <= w_width;
        r_sh_peak  <= w_peak;
        r_sh_vmin  <= w_vmin;
        r_idx      <= W_HDR;
      end else if (w_accept) begin
        if (w_last) begin
          r_idx <= W_HDR;
          r_seq <= r_seq + 8'd1;
        end else begin
          r_idx <= r_idx + 3'd1;
        end
      end
      if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end
  end

`ifdef TELEMETRY_CHECKSUM_EN
  logic [15:0] w_csum;
  assign w_csum = {HEADER_TAG, r_seq} ^ r_sh_width ^ r_sh_peak ^ r_sh_vmin;
`endif

  always_comb begin
    w_word = 16'd0;
    case (r_idx)
      W_HDR:   w_word = {HEADER_TAG, r_seq};
      W_WIDTH: w_word = r_sh_width;
      W_PEAK:  w_word = r_sh_peak;
      W_VMIN:  w_word = r_sh_vmin;
`ifdef TELEMETRY_CHECKSUM_EN
      W_CSUM:  w_word = w_csum;
`endif
      default: w_word = 16'd0;
    endcase
  end

  assign tx_valid     = (r_state == ST_SEND);
  assign frame_active = (r_state == ST_SEND);
  assign tx_data      = (r_state == ST_SEND) ? w_word : 16'd0;
  assign drop_count   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_discharge_telemetry_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_discharge_telemetry_tx
// Brief   : Self-checking bench for discharge_telemetry_tx with a
//           transaction-level frame model and table-driven pulse vectors.
// Revision: 1.0  initial release
// ============================================================================
module tb_discharge_telemetry_tx;

`ifdef TELEMETRY_CHECKSUM_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_operation = 1'b0;
  logic        report_enable = 1'b0;
  logic        tx_ready = 1'b0;
  logic [15:0] sample_current = 16'd0;
  logic [15:0] sample_voltage = 16'd0;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        frame_active;
  logic [15:0] drop_count;

  int tests = 0;
  int fails = 0;

  discharge_telemetry_tx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .is_operation   (is_operation),
    .sample_current (sample_current),
    .sample_voltage (sample_voltage),
    .report_enable  (report_enable),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .frame_active   (frame_active),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pulse samples kept in a queue, frames predicted as word lists.
  logic [15:0] exp_q[$];
  logic [15:0] rx_q[$];
  logic [31:0] pulse_q[$];
  int          m_rem = 0;
  logic [7:0]  m_seq = 8'd0;
  logic [15:0] m_drop = 16'd0;
  logic        m_op_d = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = 16'd0;

  always @(negedge clk) begin : monitor_model
    int                 w;
    logic signed [15:0] pk;
    logic signed [15:0] vm;
    logic [15:0]        hdr;
    logic               busy;
    if (!rst_n) begin
      exp_q.delete();
      pulse_q.delete();
      m_rem      = 0;
      m_seq      = 8'd0;
      m_drop     = 16'd0;
      m_op_d     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("frame_active", {31'd0, frame_active}, {31'd0, (m_rem > 0)});
      check("tx_valid", {31'd0, tx_valid}, {31'd0, (m_rem > 0)});
      check("drop_count", {16'd0, drop_count}, {16'd0, m_drop});
      if (prev_stall) begin
        check("hold_valid", {31'd0, tx_valid}, 32'd1);
        check("hold_data", {16'd0, tx_data}, {16'd0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %h expected no word", tx_data);
        end else begin
          check("word", {16'd0, tx_data}, {16'd0, exp_q.pop_front()});
        end
        rx_q.push_back(tx_data);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;

      busy = (m_rem > 0);
      if (m_rem > 0 && tx_ready) begin
        m_rem--;
        if (m_rem == 0) m_seq = m_seq + 8'd1;
      end
      if (is_operation) begin
        if (!m_op_d) pulse_q.delete();
        pulse_q.push_back({sample_current, sample_voltage});
      end else if (m_op_d && report_enable) begin
        if (busy) begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else begin
          w  = (pulse_q.size() > 65535) ? 65535 : pulse_q.size();
          pk = pulse_q[0][31:16];
          vm = pulse_q[0][15:0];
          foreach (pulse_q[j]) begin
            if ($signed(pulse_q[j][31:16]) > pk) pk = pulse_q[j][31:16];
            if ($signed(pulse_q[j][15:0]) < vm) vm = pulse_q[j][15:0];
          end
          hdr = {8'hA5, m_seq};
          exp_q.push_back(hdr);
          exp_q.push_back(w[15:0]);
          exp_q.push_back(pk);
          exp_q.push_back(vm);
`ifdef TELEMETRY_CHECKSUM_EN
          exp_q.push_back(hdr ^ w[15:0] ^ pk ^ vm);
`endif
          m_rem = FL;
        end
      end
      m_op_d = is_operation;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while ((frame_active || m_rem != 0) && c < 300) begin
      tick();
      c++;
    end
    check(name, {31'd0, (c < 300)}, 32'd1);
  endtask

  task automatic pulse_lin(input int len, input int cb, input int cs, input int vb, input int vs);
    for (int i = 0; i < len; i++) begin
      is_operation   = 1'b1;
      sample_current = 16'(cb + i * cs);
      sample_voltage = 16'(vb + i * vs);
      tick();
    end
    is_operation = 1'b0;
    tick();
  endtask

  typedef struct {
    int          len;
    int          cb;
    int          cs;
    int          vb;
    int          vs;
    logic [15:0] ew;
    logic [15:0] ep;
    logic [15:0] ev;
  } vec_t;

  vec_t tbl[4];

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    tbl[0] = '{1, 7, 0, -3, 0, 16'd1, 16'd7, 16'hFFFD};
    tbl[1] = '{5, -10, 3, 100, -20, 16'd5, 16'd2, 16'd20};
    tbl[2] = '{3, 100, -50, -5, -1, 16'd3, 16'd100, 16'hFFF9};
    tbl[3] = '{4, 32767, -1, -32768, 1, 16'd4, 16'h7FFF, 16'h8000};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_tx_data", {16'd0, tx_data}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_frame_active", {31'd0, frame_active}, 32'd0);
    check("rst_drop", {16'd0, drop_count}, 32'd0);
    rst_n = 1'b1;
    report_enable = 1'b1;
    tx_ready = 1'b1;
    tick();

    // Single ramped pulse, 500 cycles
    rx_q.delete();
    for (int i = 0; i < 500; i++) begin
      is_operation   = 1'b1;
      sample_current = 16'(i <= 40 ? i : ((80 - i) > 10 ? (80 - i) : 10));
      sample_voltage = 16'(i < 75 ? 100 - i : 25);
      tick();
    end
    is_operation = 1'b0;
    tick();
    check("ramp_latency_valid", {31'd0, tx_valid}, 32'd1);
    wait_idle("ramp_idle");
    check("ramp_len", rx_q.size(), FL);
    if (rx_q.size() >= 4) begin
      check("ramp_hdr", {16'd0, rx_q[0]}, 32'hA500);
      check("ramp_width", {16'd0, rx_q[1]}, 32'd500);
      check("ramp_peak", {16'd0, rx_q[2]}, 32'd40);
      check("ramp_vmin", {16'd0, rx_q[3]}, 32'd25);
    end
`ifdef TELEMETRY_CHECKSUM_EN
    if (rx_q.size() >= 5)
      check("ramp_csum", {16'd0, rx_q[4]}, {16'd0, 16'hA500 ^ 16'd500 ^ 16'd40 ^ 16'd25});
`endif

    // Table-driven pulses
    for (int k = 0; k < 4; k++) begin
      rx_q.delete();
      pulse_lin(tbl[k].len, tbl[k].cb, tbl[k].cs, tbl[k].vb, tbl[k].vs);
      wait_idle("tbl_idle");
      check("tbl_len", rx_q.size(), FL);
      if (rx_q.size() >= 4) begin
        check("tbl_hdr", {16'd0, rx_q[0]}, 32'hA501 + k);
        check("tbl_width", {16'd0, rx_q[1]}, {16'd0, tbl[k].ew});
        check("tbl_peak", {16'd0, rx_q[2]}, {16'd0, tbl[k].ep});
        check("tbl_vmin", {16'd0, rx_q[3]}, {16'd0, tbl[k].ev});
      end
    end

    // Backpressure on word 1 for 20 cycles
    rx_q.delete();
    pulse_lin(3, 1, 1, 9, 0);
    tick();
    tx_ready = 1'b0;
    held = tx_data;
    check("bp_held_word", {16'd0, held}, 32'd3);
    for (int i = 0; i < 20; i++) tick();
    check("bp_valid_end", {31'd0, tx_valid}, 32'd1);
    check("bp_data_end", {16'd0, tx_data}, 32'd3);
    tx_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_len", rx_q.size(), FL);
    if (rx_q.size() >= 3) check("bp_w1", {16'd0, rx_q[1]}, 32'd3);

    // Busy drop
    do_reset();
    rx_q.delete();
    tx_ready = 1'b0;
    pulse_lin(4, 2, 0, 2, 0);
    pulse_lin(2, 3, 0, 3, 0);
    check("busy_drop", {16'd0, drop_count}, 32'd1);
    tx_ready = 1'b1;
    wait_idle("busy_idle");
    check("busy_len", rx_q.size(), FL);
    if (rx_q.size() >= 2) check("busy_width", {16'd0, rx_q[1]}, 32'd4);
    rx_q.delete();
    pulse_lin(6, 1, 0, 1, 0);
    wait_idle("busy_next_idle");
    if (rx_q.size() >= 2) begin
      check("busy_next_hdr", {16'd0, rx_q[0]}, 32'hA501);
      check("busy_next_width", {16'd0, rx_q[1]}, 32'd6);
    end else check("busy_next_len", rx_q.size(), FL);

    // report_enable low, then sequence wrap
    do_reset();
    rx_q.delete();
    report_enable = 1'b0;
    for (int k = 0; k < 3; k++) pulse_lin(3, k, 1, k, 1);
    tick();
    check("noreport_words", rx_q.size(), 0);
    check("noreport_drop", {16'd0, drop_count}, 32'd0);
    report_enable = 1'b1;
    for (int k = 0; k < 257; k++) begin
      rx_q.delete();
      pulse_lin(2, k, 0, k, 0);
      wait_idle("wrap_idle");
      if (k == 255) check("wrap_hdr_ff", {16'd0, rx_q[0]}, 32'hA5FF);
      if (k == 256) check("wrap_hdr_00", {16'd0, rx_q[0]}, 32'hA500);
    end

    // Width saturation with all-negative current
    rx_q.delete();
    for (int i = 0; i < 70000; i++) begin
      is_operation   = 1'b1;
      sample_current = 16'(-5 - (i % 7));
      sample_voltage = 16'(-(i % 100));
      tick();
    end
    is_operation = 1'b0;
    tick();
    wait_idle("sat_idle");
    if (rx_q.size() >= 4) begin
      check("sat_width", {16'd0, rx_q[1]}, 32'hFFFF);
      check("sat_peak", {16'd0, rx_q[2]}, 32'hFFFB);
      check("sat_vmin", {16'd0, rx_q[3]}, 32'hFF9D);
    end else check("sat_len", rx_q.size(), FL);

    // Randomized pulses with random backpressure and report_enable
    for (int k = 0; k < 40; k++) begin
      int len;
      int gap;
      report_enable = ($urandom % 4) != 0;
      len = 1 + ($urandom % 20);
      gap = 1 + ($urandom % 12);
      for (int i = 0; i < len; i++) begin
        is_operation   = 1'b1;
        sample_current = 16'($urandom);
        sample_voltage = 16'($urandom);
        tx_ready       = ($urandom % 4) != 0;
        tick();
      end
      for (int i = 0; i < gap; i++) begin
        is_operation   = 1'b0;
        sample_current = 16'($urandom);
        sample_voltage = 16'($urandom);
        tx_ready       = ($urandom % 3) != 0;
        tick();
      end
    end
    tx_ready = 1'b1;
    wait_idle("rand_idle");
    check("rand_exp_empty", exp_q.size(), 0);

    // Reset during word 2
    report_enable = 1'b1;
    pulse_lin(2, 5, 0, 5, 0);
    tick();
    tick();
    tx_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst_active", {31'd0, frame_active}, 32'd0);
    check("midrst_data", {16'd0, tx_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    tick();
    rx_q.delete();
    pulse_lin(3, 1, 0, 1, 0);
    wait_idle("midrst_idle");
    if (rx_q.size() >= 1) check("midrst_hdr", {16'd0, rx_q[0]}, 32'hA500);
    else check("midrst_len", rx_q.size(), FL);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
